// File: rtl/mux_pkg.sv
// Shared definitions for the port-aggregation mux/demux pair.
package mux_pkg;

  localparam int unsigned PORT_NUM_W_MAX = 16;

  // Wide enough for any practical port count; narrower port numbers zero-extend into it.
  typedef logic [PORT_NUM_W_MAX-1:0] port_num_t;

  // Port-number field width: one code past the last port so invalid tags are expressible.
  function automatic int unsigned port_num_w(input int unsigned pq);
    return $clog2(pq + 1);
  endfunction

endpackage

// File: rtl/demux_fifo2.sv
// Two-entry FIFO with valid/ready on both sides; head entry drives o_data directly.
module demux_fifo2 #(
  parameter int unsigned pw_data = 8
) (
  input  logic               i_clk,
  input  logic               i_rst,
  input  logic               i_valid,
  output logic               o_ready,
  input  logic [pw_data-1:0] i_data,
  output logic               o_valid,
  input  logic               i_ready,
  output logic [pw_data-1:0] o_data,
  output logic [1:0]         count
);

  logic [pw_data-1:0] data1;
  logic               push;
  logic               pop;

  assign o_ready = (count != 2'd2);
  assign o_valid = (count != 2'd0);
  assign push    = i_valid && o_ready;
  assign pop     = o_valid && i_ready;

  // Occupancy and storage update; o_data always holds the oldest entry.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      count  <= 2'd0;
      o_data <= '0;
      data1  <= '0;
    end else begin
      unique case ({push, pop})
        2'b10: begin
          if (count == 2'd0) o_data <= i_data;
          else               data1  <= i_data;
          count <= count + 2'd1;
        end
        2'b01: begin
          o_data <= data1;
          count  <= count - 2'd1;
        end
        // Push and pop together only happen at occupancy 1: new beat becomes head.
        2'b11: o_data <= i_data;
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/demux.sv
// Steers one tagged stream to per-port buffered outputs; beats tagged for absent ports are dropped.
module demux
  import mux_pkg::*;
#(
  parameter int unsigned pq_ports = 2,
  parameter int unsigned pw_data  = 8,
  parameter int unsigned pw_cnt   = 16
) (
  input  logic                             i_clk,
  input  logic                             i_rst,
  input  logic                             i_valid,
  output logic                             o_ready,
  input  logic [pw_data-1:0]               i_data,
  input  logic [port_num_w(pq_ports)-1:0]  i_port_num,
  output logic [0:pq_ports-1]              o_valid,
  input  logic [0:pq_ports-1]              i_ready,
  output logic [pw_data-1:0]               o_data [0:pq_ports-1],
  output logic [pw_cnt-1:0]                o_drop_cnt
);

  port_num_t           port_ext;
  logic                port_valid;
  logic [0:pq_ports-1] sel;
  logic [0:pq_ports-1] fifo_rdy;
  logic [1:0]          fifo_cnt [0:pq_ports-1];

  assign port_ext   = port_num_t'(i_port_num);
  assign port_valid = (port_ext < port_num_t'(pq_ports));

  // One-hot destination decode; all zero for an invalid tag.
  always_comb begin
    sel = '0;
    for (int p = 0; p < pq_ports; p++) begin
      sel[p] = (port_ext == port_num_t'(p));
    end
  end

  // Input ready depends only on the targeted buffer; invalid tags are always accepted.
  always_comb begin
    o_ready = 1'b1;
    for (int p = 0; p < pq_ports; p++) begin
      if (sel[p]) o_ready = (fifo_cnt[p] != 2'd2);
    end
  end

  // Per-port buffers so a stalled port does not block the others.
  for (genvar g = 0; g < int'(pq_ports); g++) begin : g_port
    demux_fifo2 #(.pw_data(pw_data)) u_fifo (
      .i_clk   (i_clk),
      .i_rst   (i_rst),
      .i_valid (i_valid && sel[g]),
      .o_ready (fifo_rdy[g]),
      .i_data  (i_data),
      .o_valid (o_valid[g]),
      .i_ready (i_ready[g]),
      .o_data  (o_data[g]),
      .count   (fifo_cnt[g])
    );
  end

  // Saturating count of beats accepted with an invalid port tag.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      o_drop_cnt <= '0;
    end else if (i_valid && !port_valid && (o_drop_cnt != '1)) begin
      o_drop_cnt <= o_drop_cnt + pw_cnt'(1);
    end
  end

endmodule

// File: tb/tb_demux.sv
// Directed table plus random scoreboard bench for demux.
module tb_demux;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  // Two-port instance with a 2-bit drop counter
  logic       v2;
  logic       ordy2;
  logic [7:0] d2;
  logic [1:0] p2;
  logic [0:1] ov2;
  logic [0:1] r2;
  logic [7:0] od2 [0:1];
  logic [1:0] drop2;

  demux #(.pq_ports(2), .pw_data(8), .pw_cnt(2)) dut2 (
    .i_clk(clk), .i_rst(rst), .i_valid(v2), .o_ready(ordy2), .i_data(d2),
    .i_port_num(p2), .o_valid(ov2), .i_ready(r2), .o_data(od2), .o_drop_cnt(drop2)
  );

  // Four-port instance for the random run
  logic        v4;
  logic        ordy4;
  logic [15:0] d4;
  logic [2:0]  p4;
  logic [0:3]  ov4;
  logic [0:3]  r4;
  logic [15:0] od4 [0:3];
  logic [15:0] drop4;

  demux #(.pq_ports(4), .pw_data(16), .pw_cnt(16)) dut4 (
    .i_clk(clk), .i_rst(rst), .i_valid(v4), .o_ready(ordy4), .i_data(d4),
    .i_port_num(p4), .o_valid(ov4), .i_ready(r4), .o_data(od4), .o_drop_cnt(drop4)
  );

  int n_cmp  = 0;
  int n_fail = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Drive dut2 inputs just after the edge, then move to the sampling edge
  task automatic step2(input logic v, input logic [1:0] p, input logic [7:0] d,
                       input logic rd0, input logic rd1);
    @(posedge clk);
    #1;
    v2 = v; p2 = p; d2 = d; r2[0] = rd0; r2[1] = rd1;
    @(negedge clk);
  endtask

  typedef struct {
    logic       v;
    logic [1:0] p;
    logic [7:0] d;
    logic       rd0, rd1;
    logic       e_rdy, e_v0, e_v1;
    logic [7:0] e_d0, e_d1;
    logic [1:0] e_drop;
  } vec_t;

  localparam int unsigned NV = 21;
  vec_t tbl [NV];

  logic [15:0] q [4][$];
  int sent, cyc, exp_drop, seq;
  logic acc;
  logic [15:0] hd;

  initial begin
    //             v  p     d      r0 r1  rdy v0 v1 d0     d1     drop
    // stream to port 1, both ports ready
    tbl[0]  = '{1, 2'd1, 8'h11, 1, 1,  1, 0, 0, 8'h00, 8'h00, 2'd0};
    tbl[1]  = '{1, 2'd1, 8'h22, 1, 1,  1, 0, 1, 8'h00, 8'h11, 2'd0};
    tbl[2]  = '{1, 2'd1, 8'h33, 1, 1,  1, 0, 1, 8'h00, 8'h22, 2'd0};
    tbl[3]  = '{0, 2'd0, 8'h00, 1, 1,  1, 0, 1, 8'h00, 8'h33, 2'd0};
    tbl[4]  = '{0, 2'd0, 8'h00, 1, 1,  1, 0, 0, 8'h00, 8'h00, 2'd0};
    // port 0 stalled, fill it, interleave port 1, release
    tbl[5]  = '{1, 2'd0, 8'hA0, 0, 1,  1, 0, 0, 8'h00, 8'h00, 2'd0};
    tbl[6]  = '{1, 2'd0, 8'hA1, 0, 1,  1, 1, 0, 8'hA0, 8'h00, 2'd0};
    tbl[7]  = '{1, 2'd0, 8'hA2, 0, 1,  0, 1, 0, 8'hA0, 8'h00, 2'd0};
    tbl[8]  = '{1, 2'd1, 8'hB0, 0, 1,  1, 1, 0, 8'hA0, 8'h00, 2'd0};
    tbl[9]  = '{1, 2'd0, 8'hA2, 0, 1,  0, 1, 1, 8'hA0, 8'hB0, 2'd0};
    tbl[10] = '{1, 2'd0, 8'hA2, 1, 1,  0, 1, 0, 8'hA0, 8'h00, 2'd0};
    tbl[11] = '{1, 2'd0, 8'hA2, 1, 1,  1, 1, 0, 8'hA1, 8'h00, 2'd0};
    tbl[12] = '{0, 2'd0, 8'h00, 1, 1,  1, 1, 0, 8'hA2, 8'h00, 2'd0};
    tbl[13] = '{0, 2'd0, 8'h00, 1, 1,  1, 0, 0, 8'h00, 8'h00, 2'd0};
    // invalid ports 2 and 3: dropped, counter saturates at 3
    tbl[14] = '{1, 2'd2, 8'h77, 1, 1,  1, 0, 0, 8'h00, 8'h00, 2'd0};
    tbl[15] = '{1, 2'd3, 8'h78, 1, 1,  1, 0, 0, 8'h00, 8'h00, 2'd1};
    tbl[16] = '{1, 2'd2, 8'h79, 1, 1,  1, 0, 0, 8'h00, 8'h00, 2'd2};
    tbl[17] = '{0, 2'd0, 8'h00, 1, 1,  1, 0, 0, 8'h00, 8'h00, 2'd3};
    tbl[18] = '{1, 2'd2, 8'h7A, 1, 1,  1, 0, 0, 8'h00, 8'h00, 2'd3};
    tbl[19] = '{1, 2'd3, 8'h7B, 1, 1,  1, 0, 0, 8'h00, 8'h00, 2'd3};
    tbl[20] = '{0, 2'd0, 8'h00, 1, 1,  1, 0, 0, 8'h00, 8'h00, 2'd3};

    rst = 1'b1;
    v2 = 1'b0; p2 = '0; d2 = '0; r2 = '0;
    v4 = 1'b0; p4 = '0; d4 = '0; r4 = '0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    // Idle after reset
    @(negedge clk);
    chk("rst_valid", 32'(ov2), 32'h0);
    chk("rst_drop", 32'(drop2), 32'h0);
    chk("rst_ready", 32'(ordy2), 32'h1);
    chk("rst_data0", 32'(od2[0]), 32'h0);
    chk("rst_data1", 32'(od2[1]), 32'h0);

    // Directed table
    for (int i = 0; i < int'(NV); i++) begin
      step2(tbl[i].v, tbl[i].p, tbl[i].d, tbl[i].rd0, tbl[i].rd1);
      chk($sformatf("v%0d_ready", i), 32'(ordy2), 32'(tbl[i].e_rdy));
      chk($sformatf("v%0d_valid0", i), 32'(ov2[0]), 32'(tbl[i].e_v0));
      chk($sformatf("v%0d_valid1", i), 32'(ov2[1]), 32'(tbl[i].e_v1));
      if (tbl[i].e_v0) chk($sformatf("v%0d_data0", i), 32'(od2[0]), 32'(tbl[i].e_d0));
      if (tbl[i].e_v1) chk($sformatf("v%0d_data1", i), 32'(od2[1]), 32'(tbl[i].e_d1));
      chk($sformatf("v%0d_drop", i), 32'(drop2), 32'(tbl[i].e_drop));
    end

    // Fill both buffers, then reset mid-operation
    step2(1, 2'd0, 8'hC0, 0, 0);
    step2(1, 2'd0, 8'hC1, 0, 0);
    step2(1, 2'd1, 8'hD0, 0, 0);
    step2(1, 2'd1, 8'hD1, 0, 0);
    step2(1, 2'd0, 8'hC2, 0, 0);
    chk("full_ready0", 32'(ordy2), 32'h0);
    chk("full_valid", 32'(ov2), 32'h3);
    step2(1, 2'd1, 8'hD2, 0, 0);
    chk("full_ready1", 32'(ordy2), 32'h0);
    @(posedge clk);
    #1 rst = 1'b1; v2 = 1'b0;
    @(posedge clk);
    #1 rst = 1'b0;
    v2 = 1'b1; p2 = 2'd0; d2 = 8'h55; r2 = 2'b11;
    @(negedge clk);
    chk("mrst_valid", 32'(ov2), 32'h0);
    chk("mrst_drop", 32'(drop2), 32'h0);
    chk("mrst_data0", 32'(od2[0]), 32'h0);
    chk("mrst_data1", 32'(od2[1]), 32'h0);
    step2(0, 2'd0, 8'h00, 1, 1);
    chk("post_valid", 32'(ov2), 32'h2);
    chk("post_data0", 32'(od2[0]), 32'h55);
    step2(0, 2'd0, 8'h00, 1, 1);
    chk("post_alone", 32'(ov2), 32'h0);

    // Random traffic on the four-port instance
    sent = 0; cyc = 0; exp_drop = 0; seq = 0;
    @(posedge clk);
    #1;
    v4 = 1'b0;
    r4 = '1;
    while (sent < 10000 && cyc < 60000) begin
      @(negedge clk);
      acc = v4 && ordy4;
      if (acc) begin
        if (p4 < 3'd4) q[p4[1:0]].push_back(d4);
        else           exp_drop++;
        sent++;
      end
      for (int p = 0; p < 4; p++) begin
        if (ov4[p] && r4[p]) begin
          if (q[p].size() == 0) begin
            chk($sformatf("rnd_dup_p%0d", p), 32'(od4[p]), 32'hFFFF_FFFF);
          end else begin
            hd = q[p].pop_front();
            chk($sformatf("rnd_data_p%0d", p), 32'(od4[p]), 32'(hd));
          end
        end
      end
      @(posedge clk);
      #1;
      if (!v4 || acc) begin
        v4  = ($urandom % 4) != 0;
        p4  = (($urandom % 5) == 0) ? 3'(4 + ($urandom % 4)) : 3'($urandom % 4);
        d4  = 16'(seq);
        seq++;
      end
      for (int p = 0; p < 4; p++) r4[p] = ($urandom % 4) != 0;
      cyc++;
    end
    if (cyc >= 60000) chk("rnd_timeout", 32'(sent), 32'd10000);

    // Drain and confirm nothing left or lost
    v4 = 1'b0;
    r4 = '1;
    repeat (10) begin
      @(negedge clk);
      for (int p = 0; p < 4; p++) begin
        if (ov4[p]) begin
          if (q[p].size() == 0) begin
            chk($sformatf("drain_dup_p%0d", p), 32'(od4[p]), 32'hFFFF_FFFF);
          end else begin
            hd = q[p].pop_front();
            chk($sformatf("drain_data_p%0d", p), 32'(od4[p]), 32'(hd));
          end
        end
      end
      @(posedge clk);
      #1;
    end
    @(negedge clk);
    for (int p = 0; p < 4; p++) chk($sformatf("rnd_left_p%0d", p), 32'(q[p].size()), 32'd0);
    chk("rnd_idle", 32'(ov4), 32'h0);
    chk("rnd_drop", 32'(drop4), 32'(exp_drop));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
